// File: rtl/wb_pipe_reg.sv
// wb_pipe_reg: Memory->Writeback pipeline register with per-stage valid, stall/flush,
// x0 write suppression and a retired-instruction counter.
module wb_pipe_reg #(
  parameter int DATA_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int RESULT_SRC_WIDTH = 2,
  parameter int DEPTH            = 1,
  parameter int CNT_WIDTH        = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        StallW,
  input  logic                        FlushW,
  input  logic                        ValidM,
  input  logic [DATA_WIDTH-1:0]       ALUResultM,
  input  logic [DATA_WIDTH-1:0]       PCPlus4M,
  input  logic [DATA_WIDTH-1:0]       ReadDataM,
  input  logic [REG_ADDR_WIDTH-1:0]   RdM,
  input  logic                        RegWriteM,
  input  logic [RESULT_SRC_WIDTH-1:0] ResultSrcM,
  output logic [DATA_WIDTH-1:0]       ALUResultW,
  output logic [DATA_WIDTH-1:0]       PCPlus4W,
  output logic [DATA_WIDTH-1:0]       ReadDataW,
  output logic [REG_ADDR_WIDTH-1:0]   RdW,
  output logic                        RegWriteW,
  output logic [RESULT_SRC_WIDTH-1:0] ResultSrcW,
  output logic                        ValidW,
  output logic [CNT_WIDTH-1:0]        InstRetW
);
  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("wb_pipe_reg: DEPTH must be in 1..4");
  end
  typedef struct packed {
    logic                        valid;
    logic                        reg_write;
    logic [RESULT_SRC_WIDTH-1:0] result_src;
    logic [REG_ADDR_WIDTH-1:0]   rd;
    logic [DATA_WIDTH-1:0]       alu_result;
    logic [DATA_WIDTH-1:0]       pc_plus4;
    logic [DATA_WIDTH-1:0]       read_data;
  } stage_t;
  stage_t st  [DEPTH];
  stage_t nxt [DEPTH];
  logic [CNT_WIDTH-1:0] cnt;
  // nxt[i] is what stage i loads on an advance; bubbles and x0 never write
  always_comb begin
    nxt[0] = '{valid: ValidM, reg_write: RegWriteM & ValidM & (RdM != '0),
               result_src: ResultSrcM, rd: RdM, alu_result: ALUResultM,
               pc_plus4: PCPlus4M, read_data: ReadDataM};
    for (int i = 1; i < DEPTH; i++) nxt[i] = st[i-1];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= '0;
      cnt <= '0;
    end else if (FlushW) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= '0;
    end else if (!StallW) begin
      st  <= nxt;
      cnt <= cnt + CNT_WIDTH'(nxt[DEPTH-1].valid);
    end
  end
  assign ALUResultW = st[DEPTH-1].alu_result;
  assign PCPlus4W   = st[DEPTH-1].pc_plus4;
  assign ReadDataW  = st[DEPTH-1].read_data;
  assign RdW        = st[DEPTH-1].rd;
  assign RegWriteW  = st[DEPTH-1].reg_write;
  assign ResultSrcW = st[DEPTH-1].result_src;
  assign ValidW     = st[DEPTH-1].valid;
  assign InstRetW   = cnt;
endmodule
